// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: AXI-Stream frame bytes in, preamble/SFD + data + pad + FCS out,
// followed by a programmable inter-frame gap. Single gmii_txc domain.
module gmii_tx_framer #(
  parameter int unsigned MIN_FRAME = 60,
  parameter int unsigned IFG_BYTES = 12,
  parameter int unsigned PRE_LEN   = 7
) (
  input  logic       gmii_txc,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_td,
  output logic       tx_busy,
  output logic       underflow
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PRE_W = 4;
  localparam int unsigned IFG_W = 8;
  localparam int unsigned CRC_W = 32;

  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_LEN);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_BYTES - 1);
  localparam logic [CRC_W-1:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DRAIN,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t           state_q, state_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic [7:0]       td_q, td_d;
  logic             busy_q, busy_d;
  logic             underflow_q, underflow_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic [1:0]       fcs_q, fcs_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [CRC_W-1:0] fcs_word;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] crc,
                                                input logic [7:0] data);
    logic [CRC_W-1:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign cnt_inc  = (cnt_q < MIN_CNT) ? cnt_q + CNT_W'(1) : cnt_q;
  assign fcs_word = ~crc_q >> {fcs_q, 3'b000};

  assign s_axis_tready = (state_q == S_DATA) || (state_q == S_DRAIN);

  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign gmii_td    = td_q;
  assign tx_busy    = busy_q;
  assign underflow  = underflow_q;

  // Each state decides the byte presented on the next edge.
  always_comb begin
    state_d     = state_q;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    td_d        = 8'h00;
    underflow_d = 1'b0;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    ifg_d       = ifg_q;
    fcs_d       = fcs_q;

    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid) begin
          state_d = S_PRE;
          tx_en_d = 1'b1;
          td_d    = 8'h55;
          pre_d   = PRE_W'(1);
        end
      end

      S_PRE: begin
        tx_en_d = 1'b1;
        if (pre_q == PRE_LAST) begin
          td_d    = 8'hD5;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          td_d  = 8'h55;
          pre_d = pre_q + PRE_W'(1);
        end
      end

      S_DATA: begin
        tx_en_d = 1'b1;
        if (s_axis_tvalid) begin
          td_d    = s_axis_tdata;
          tx_er_d = s_axis_tuser;
          crc_d   = crc_byte(crc_q, s_axis_tdata);
          cnt_d   = cnt_inc;
          if (s_axis_tlast) begin
            fcs_d   = 2'd0;
            state_d = (cnt_inc < MIN_CNT) ? S_PAD : S_FCS;
          end
        end else begin
          // Starved mid-frame: mark the wire with one error byte and abandon the frame.
          tx_er_d     = 1'b1;
          underflow_d = 1'b1;
          state_d     = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          ifg_d   = '0;
          state_d = S_IFG;
        end
      end

      S_PAD: begin
        tx_en_d = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
        cnt_d   = cnt_inc;
        if (cnt_inc == MIN_CNT) begin
          fcs_d   = 2'd0;
          state_d = S_FCS;
        end
      end

      S_FCS: begin
        tx_en_d = 1'b1;
        td_d    = fcs_word[7:0];
        fcs_d   = fcs_q + 2'd1;
        if (fcs_q == 2'd3) begin
          ifg_d   = '0;
          state_d = S_IFG;
        end
      end

      S_IFG: begin
        if (ifg_q == IFG_LAST) begin
          ifg_d   = '0;
          state_d = S_IDLE;
        end else begin
          ifg_d = ifg_q + IFG_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge gmii_txc) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      td_q        <= 8'h00;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
      crc_q       <= CRC_INIT;
      cnt_q       <= '0;
      pre_q       <= '0;
      ifg_q       <= '0;
      fcs_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      td_q        <= td_d;
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      ifg_q       <= ifg_d;
      fcs_q       <= fcs_d;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: random frames checked against a byte-stream model of the
// expected GMII output (preamble, SFD, data, zero pad, bit-serial CRC-32 FCS).
module tb_gmii_tx_framer;

  localparam int PRE  = 7;
  localparam int IFG  = 12;
  localparam int MINF = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic       tuser = 1'b0;
  logic       sel = 1'b1;

  logic       v0, v1, rdy0, rdy1, en0, en1, er0, er1, busy0, busy1, uf0, uf1;
  logic [7:0] td0, td1;
  logic       m_en, m_er, m_rdy, m_busy, m_uf;
  logic [7:0] m_td;

  always #4 clk = ~clk;

  assign v0 = tvalid & ~sel;
  assign v1 = tvalid & sel;

  gmii_tx_framer #(.MIN_FRAME(0)) u_dut0 (
    .gmii_txc(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(v0),
    .s_axis_tready(rdy0), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .gmii_tx_en(en0), .gmii_tx_er(er0), .gmii_td(td0), .tx_busy(busy0), .underflow(uf0)
  );

  gmii_tx_framer u_dut (
    .gmii_txc(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(v1),
    .s_axis_tready(rdy1), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .gmii_tx_en(en1), .gmii_tx_er(er1), .gmii_td(td1), .tx_busy(busy1), .underflow(uf1)
  );

  assign m_en   = sel ? en1   : en0;
  assign m_er   = sel ? er1   : er0;
  assign m_td   = sel ? td1   : td0;
  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_uf   = sel ? uf1   : uf0;

  int checks = 0;
  int failures = 0;

  logic [7:0] frm [256];
  logic [7:0] cap_d [$];
  logic       cap_er [$];
  logic [7:0] exp_d [$];
  logic       exp_er [$];

  int uf_cnt, idle_run, last_gap, rdy_viol, pos, rdy_lo, rdy_hi;
  bit seen, chk_rdy;

  // Capture every tx_en byte; track gaps and tready legality by frame position.
  always @(negedge clk) begin
    if (m_uf) uf_cnt++;
    if (m_en) begin
      if (seen && idle_run > 0) last_gap = idle_run;
      cap_d.push_back(m_td);
      cap_er.push_back(m_er);
      if (chk_rdy && (m_rdy !== ((pos >= rdy_lo) && (pos <= rdy_hi)))) rdy_viol++;
      pos++;
      idle_run = 0;
      seen = 1'b1;
    end else begin
      if (chk_rdy && m_rdy) rdy_viol++;
      idle_run++;
      pos = 0;
    end
  end

  function automatic logic [31:0] crc_bits(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ b[k];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  task automatic clear_mon();
    cap_d.delete(); cap_er.delete(); exp_d.delete(); exp_er.delete();
    uf_cnt = 0; idle_run = 0; last_gap = -1; rdy_viol = 0; pos = 0;
    seen = 1'b0; chk_rdy = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) frm[i] = 8'($urandom);
  endtask

  task automatic add_pre();
    for (int i = 0; i < PRE; i++) begin exp_d.push_back(8'h55); exp_er.push_back(1'b0); end
    exp_d.push_back(8'hD5); exp_er.push_back(1'b0);
  endtask

  // Expected wire bytes for one complete frame.
  task automatic add_exp(input int n, input int minf, input int user_at);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    int          tot;
    add_pre();
    crc = 32'hFFFF_FFFF;
    tot = (n < minf) ? minf : n;
    for (int i = 0; i < tot; i++) begin
      b = (i < n) ? frm[i] : 8'h00;
      exp_d.push_back(b);
      exp_er.push_back(i == user_at);
      crc = crc_bits(crc, b);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) begin
      exp_d.push_back(fcs[7:0]); exp_er.push_back(1'b0);
      fcs = fcs >> 8;
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (cap_d.size() < exp_d.size()) ? cap_d.size() : exp_d.size();
    for (int i = 0; i < n; i++)
      if (cap_d[i] !== exp_d[i] || cap_er[i] !== exp_er[i]) return i;
    if (cap_d.size() != exp_d.size()) return n;
    return -1;
  endfunction

  task automatic send(input int n, input int user_at, input int gap_at);
    logic acc;
    int   budget;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        tvalid = 1'b0; budget = 0;
        do begin @(negedge clk); acc = m_rdy; @(posedge clk); #1; budget++; end
        while (!acc && budget < 1000);
      end
      tdata = frm[i]; tlast = (i == n - 1); tuser = (i == user_at); tvalid = 1'b1;
      budget = 0;
      do begin @(negedge clk); acc = m_rdy; @(posedge clk); #1; budget++; end
      while (!acc && budget < 1000);
      if (!acc) begin
        checks++; failures++;
        $display("FAIL send_timeout beat=%0d waited=%0d", i, budget);
        break;
      end
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (m_busy && k < 3000) begin @(negedge clk); k++; end
    if (m_busy) begin
      checks++; failures++;
      $display("FAIL idle_timeout busy=%0b cycles=%0d", m_busy, k);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (en1 !== 1'b0)    begin failures++; $display("FAIL rst_tx_en got=%b exp=0", en1); end
    checks++; if (er1 !== 1'b0)    begin failures++; $display("FAIL rst_tx_er got=%b exp=0", er1); end
    checks++; if (td1 !== 8'h00)   begin failures++; $display("FAIL rst_td got=%h exp=00", td1); end
    checks++; if (busy1 !== 1'b0)  begin failures++; $display("FAIL rst_busy got=%b exp=0", busy1); end
    checks++; if (uf1 !== 1'b0)    begin failures++; $display("FAIL rst_underflow got=%b exp=0", uf1); end
    checks++; if (rdy1 !== 1'b0)   begin failures++; $display("FAIL rst_tready got=%b exp=0", rdy1); end
    checks++; if ({en0, busy0} !== 2'b00) begin failures++; $display("FAIL rst_dut0 got=%b exp=00", {en0, busy0}); end
    #1 rst = 1'b0;
  endtask

  task automatic test_crc_vector();
    logic [31:0] fcs;
    int          d;
    sel = 1'b0;
    clear_mon();
    for (int i = 0; i < 9; i++) frm[i] = 8'(8'h31 + i);
    add_exp(9, 0, -1);
    send(9, -1, -1);
    wait_idle();
    checks++;
    if (cap_d.size() != 21) begin failures++; $display("FAIL crc_vec_len got=%0d exp=21", cap_d.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL crc_vec_bytes first_bad_idx=%0d exp=-1", d); end
    if (cap_d.size() >= 21) begin
      fcs = {cap_d[20], cap_d[19], cap_d[18], cap_d[17]};
      checks++;
      if (fcs !== 32'hCBF4_3926) begin failures++; $display("FAIL crc_vec_fcs got=%h exp=cbf43926", fcs); end
    end
    sel = 1'b1;
  endtask

  task automatic test_pad();
    int d;
    clear_mon();
    fill(14);
    add_exp(14, MINF, -1);
    send(14, -1, -1);
    wait_idle();
    checks++;
    if (cap_d.size() != 72) begin failures++; $display("FAIL pad_len got=%0d exp=72", cap_d.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL pad_bytes first_bad_idx=%0d exp=-1", d); end
  endtask

  task automatic test_random_frames();
    int n, d;
    for (int f = 0; f < 6; f++) begin
      clear_mon();
      n = $urandom_range(1, 120);
      fill(n);
      add_exp(n, MINF, -1);
      send(n, -1, -1);
      wait_idle();
      d = first_diff();
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL rand_frame len=%0d first_bad_idx=%0d got_len=%0d exp_len=%0d",
                 n, d, cap_d.size(), exp_d.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    int d;
    clear_mon();
    chk_rdy = 1'b1; rdy_lo = PRE; rdy_hi = PRE + 63;
    fill(64); add_exp(64, MINF, -1); send(64, -1, -1);
    fill(64); add_exp(64, MINF, -1); send(64, -1, -1);
    wait_idle();
    chk_rdy = 1'b0;
    checks++;
    if (last_gap != IFG) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", last_gap, IFG); end
    checks++;
    if (cap_d.size() != 152) begin failures++; $display("FAIL b2b_len got=%0d exp=152", cap_d.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL b2b_bytes first_bad_idx=%0d exp=-1", d); end
    checks++;
    if (rdy_viol != 0) begin failures++; $display("FAIL b2b_tready violations=%0d exp=0", rdy_viol); end
  endtask

  task automatic test_underflow();
    int d, busy_cyc;
    clear_mon();
    fill(40);
    add_pre();
    for (int i = 0; i < 20; i++) begin exp_d.push_back(frm[i]); exp_er.push_back(1'b0); end
    exp_d.push_back(8'h00); exp_er.push_back(1'b1);
    send(40, -1, 20);
    busy_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!m_busy) break;
      busy_cyc++;
    end
    wait_idle();
    checks++;
    if (uf_cnt != 1) begin failures++; $display("FAIL uf_pulses got=%0d exp=1", uf_cnt); end
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL uf_bytes first_bad_idx=%0d got_len=%0d exp_len=%0d", d, cap_d.size(), exp_d.size()); end
    checks++;
    if (busy_cyc != IFG) begin failures++; $display("FAIL uf_ifg_busy got=%0d exp=%0d", busy_cyc, IFG); end
  endtask

  task automatic test_tuser();
    int n, d, er_cnt;
    clear_mon();
    n = $urandom_range(20, 80);
    fill(n);
    add_exp(n, MINF, 4);
    send(n, 4, -1);
    wait_idle();
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL tuser_bytes len=%0d first_bad_idx=%0d exp=-1", n, d); end
    er_cnt = 0;
    foreach (cap_er[i]) if (cap_er[i]) er_cnt++;
    checks++;
    if (er_cnt != 1 || cap_er.size() <= PRE + 5 || cap_er[PRE + 5] !== 1'b1) begin
      failures++; $display("FAIL tuser_er count=%0d exp=1", er_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int target, k, d;
    clear_mon();
    fill(60);
    send(60, -1, -1);
    target = PRE + 1 + 60 + 2;
    k = 0;
    do begin @(negedge clk); #1; k++; end while (cap_d.size() < target && k < 500);
    checks++;
    if (cap_d.size() != target) begin failures++; $display("FAIL rstmid_reach got=%0d exp=%0d", cap_d.size(), target); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_en, m_td, m_busy} !== 10'h000) begin
      failures++; $display("FAIL rstmid_out got_en=%b got_td=%h got_busy=%b exp=0/00/0", m_en, m_td, m_busy);
    end
    clear_mon();
    fill(30);
    add_exp(30, MINF, -1);
    send(30, -1, -1);
    wait_idle();
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL rstmid_next first_bad_idx=%0d exp=-1", d); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_crc_vector();
    test_pad();
    test_random_frames();
    test_back_to_back();
    test_underflow();
    test_tuser();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
